arm_pipelined_flag_bank_unit: RTL and testbench

//   Next-generation execute-stage condition unit. Holds NUM_BANKS banked NZCV flag registers (one per processor mode).

---
 rtl/arm_cond_pkg.sv | 14 +
 rtl/arm_cond_eval.sv | 29 ++
 rtl/arm_pipelined_flag_bank_unit.sv | 90 +++++++++
 tb/tb_arm_pipelined_flag_bank_unit.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/arm_cond_pkg.sv
// arm_cond_pkg: condition codes, NZCV flag layout and stored flag width (5 bits with COND_UNIT_Q_FLAG_EN)
package arm_cond_pkg;
  typedef enum logic [3:0] {EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV} cond_e;
  typedef struct packed {logic n; logic z; logic c; logic v;} flags_t;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
`ifdef COND_UNIT_Q_FLAG_EN
  localparam int FLAG_W = 5;
`else
  localparam int FLAG_W = 4;
`endif
endpackage

// File: rtl/arm_cond_eval.sv
// arm_cond_eval: combinational ARM condition-code check against one NZCV set
module arm_cond_eval
  import arm_cond_pkg::*;
(
  input  cond_e  cond_i,
  input  flags_t flags_i,
  output logic   pass_o
);
  always_comb begin
    pass_o = 1'b1;
    case (cond_i)
      EQ: pass_o = flags_i.z;
      NE: pass_o = ~flags_i.z;
      CS: pass_o = flags_i.c;
      CC: pass_o = ~flags_i.c;
      MI: pass_o = flags_i.n;
      PL: pass_o = ~flags_i.n;
      VS: pass_o = flags_i.v;
      VC: pass_o = ~flags_i.v;
      HI: pass_o = flags_i.c & ~flags_i.z;
      LS: pass_o = ~flags_i.c | flags_i.z;
      GE: pass_o = flags_i.n == flags_i.v;
      LT: pass_o = flags_i.n != flags_i.v;
      GT: pass_o = ~flags_i.z & (flags_i.n == flags_i.v);
      LE: pass_o = flags_i.z | (flags_i.n != flags_i.v);
      default: pass_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/arm_pipelined_flag_bank_unit.sv
// arm_pipelined_flag_bank_unit: banked NZCV flags, condition check and saved-flags stack.
// COND_UNIT_Q_FLAG_EN adds a sticky Q bit per bank and on the stack.
module arm_pipelined_flag_bank_unit
  import arm_cond_pkg::*;
#(
  parameter int NUM_BANKS   = 2,
  parameter int STACK_DEPTH = 4,
  localparam int BANK_W     = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1
) (
  input  logic              i_CLK,
  input  logic              i_RESET,
  input  logic              i_Valid_Execute,
  input  logic [BANK_W-1:0] i_Bank_Sel,
  input  logic [3:0]        i_Cond_Execute,
  input  logic [1:0]        i_Flag_Write_Execute,
  input  logic [3:0]        i_ALU_Flags,
  input  logic              i_Flag_Load,
  input  logic [FLAG_W-1:0] i_Flag_Load_Data,
  input  logic              i_Push,
  input  logic              i_Pop,
`ifdef COND_UNIT_Q_FLAG_EN
  input  logic              i_ALU_Sat,
  output logic              o_Q_Flag,
`endif
  output logic [3:0]        o_Flags,
  output logic              o_CondEx_Execute,
  output logic              o_Stack_Full,
  output logic              o_Stack_Empty,
  output logic              o_Stack_Err
);
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int SLOTS = 1 << SP_W;
  logic [FLAG_W-1:0] bank_q [NUM_BANKS];
  logic [FLAG_W-1:0] stk_q [SLOTS];
  logic [SP_W-1:0]   sp_q;
  logic              err_q;
  logic              bank_ok, pass, push_ok, pop_ok, bad;
  logic [BANK_W-1:0] act;
  logic [FLAG_W-1:0] cur, alu_d, bank_d;

  // out-of-range selects fall back to bank 0 for reads and block all writes
  assign bank_ok = {1'b0, i_Bank_Sel} < (BANK_W + 1)'(NUM_BANKS);
  assign act     = bank_ok ? i_Bank_Sel : '0;
  assign cur     = bank_q[act];

  arm_cond_eval u_eval (
    .cond_i (cond_e'(i_Cond_Execute)),
    .flags_i(flags_t'(cur[3:0])),
    .pass_o (pass)
  );

  assign o_CondEx_Execute = pass & i_Valid_Execute;
  assign o_Flags          = cur[3:0];
  assign o_Stack_Full     = sp_q == SP_W'(STACK_DEPTH);
  assign o_Stack_Empty    = sp_q == '0;
  assign o_Stack_Err      = err_q;
  assign push_ok          = i_Push & ~i_Pop & ~o_Stack_Full;
  assign pop_ok           = i_Pop & ~i_Push & ~o_Stack_Empty;
  assign bad              = (i_Push & i_Pop) | (i_Push & o_Stack_Full) | (i_Pop & o_Stack_Empty);
`ifdef COND_UNIT_Q_FLAG_EN
  assign o_Q_Flag = cur[FLAG_W-1];
`endif

  always_comb begin
    alu_d = cur;
    alu_d[FLAG_N:FLAG_Z] = (o_CondEx_Execute & i_Flag_Write_Execute[1]) ? i_ALU_Flags[3:2] : cur[FLAG_N:FLAG_Z];
    alu_d[FLAG_C:FLAG_V] = (o_CondEx_Execute & i_Flag_Write_Execute[0]) ? i_ALU_Flags[1:0] : cur[FLAG_C:FLAG_V];
`ifdef COND_UNIT_Q_FLAG_EN
    alu_d[FLAG_W-1] = cur[FLAG_W-1] | (o_CondEx_Execute & i_ALU_Sat);
`endif
    bank_d = pop_ok ? stk_q[sp_q - SP_W'(1)] : i_Flag_Load ? i_Flag_Load_Data : alu_d;
  end

  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      for (int b = 0; b < NUM_BANKS; b++) bank_q[b] <= '0;
      for (int s = 0; s < SLOTS; s++) stk_q[s] <= '0;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (bank_ok) bank_q[act] <= bank_d;
      if (push_ok) begin
        stk_q[sp_q] <= cur;
        sp_q        <= sp_q + SP_W'(1);
      end
      if (pop_ok) sp_q <= sp_q - SP_W'(1);
      if (bad) err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_arm_pipelined_flag_bank_unit.sv
// tb_arm_pipelined_flag_bank_unit: scoreboard bench for the banked flag unit (default build)
module tb_arm_pipelined_flag_bank_unit;
  localparam logic [3:0] C_EQ = 4'd0, C_NE = 4'd1, C_MI = 4'd4, C_AL = 4'd14;
  logic clk = 1'b0, rst = 1'b1, valid = 1'b0, bsel = 1'b0, ld = 1'b0, push = 1'b0, pop = 1'b0;
  logic [3:0] cond = C_AL, alu = '0, ld_data = '0;
  logic [1:0] wr = '0;
  logic [3:0] flags, e;
  logic condex, full, empty, err;
  logic [3:0] exp_q[$];
  logic [3:0] stk_m[$];
  int pass_n = 0, total_n = 0;

  always #5 clk = ~clk;

  arm_pipelined_flag_bank_unit dut (
    .i_CLK(clk), .i_RESET(rst), .i_Valid_Execute(valid), .i_Bank_Sel(bsel),
    .i_Cond_Execute(cond), .i_Flag_Write_Execute(wr), .i_ALU_Flags(alu),
    .i_Flag_Load(ld), .i_Flag_Load_Data(ld_data), .i_Push(push), .i_Pop(pop),
    .o_Flags(flags), .o_CondEx_Execute(condex), .o_Stack_Full(full),
    .o_Stack_Empty(empty), .o_Stack_Err(err)
  );

  task automatic idle();
    valid = 0; cond = C_AL; wr = 0; alu = 0; ld = 0; ld_data = 0; push = 0; pop = 0; bsel = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle(); rst = 1; #2; rst = 0; tick();
  endtask

  task automatic load(input logic [3:0] v);
    idle(); ld = 1; ld_data = v; tick(); idle();
  endtask

  task automatic test_reset();
    idle(); rst = 1; #1;
    total_n++; if (flags !== 4'b0000) $display("FAIL reset_flags got=%b exp=0000", flags); else pass_n++;
    total_n++; if (empty !== 1'b1) $display("FAIL reset_empty got=%b exp=1", empty); else pass_n++;
    total_n++; if (full !== 1'b0) $display("FAIL reset_full got=%b exp=0", full); else pass_n++;
    total_n++; if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else pass_n++;
    valid = 1; cond = C_EQ; #1;
    total_n++; if (condex !== 1'b0) $display("FAIL reset_cond_eq got=%b exp=0", condex); else pass_n++;
    cond = C_AL; #1;
    total_n++; if (condex !== 1'b1) $display("FAIL reset_cond_al got=%b exp=1", condex); else pass_n++;
    rst = 0; idle(); tick();
  endtask

  task automatic test_alu_write();
    idle(); valid = 1; cond = C_AL; alu = 4'b0100; wr = 2'b11;
    exp_q.push_back(4'b0100); tick();
    e = exp_q.pop_front();
    total_n++; if (flags !== e) $display("FAIL alu_write got=%b exp=%b", flags, e); else pass_n++;
    cond = C_NE; alu = 4'b1000; #1;
    total_n++; if (condex !== 1'b0) $display("FAIL alu_ne_condex got=%b exp=0", condex); else pass_n++;
    exp_q.push_back(4'b0100); tick();
    e = exp_q.pop_front();
    total_n++; if (flags !== e) $display("FAIL alu_gated got=%b exp=%b", flags, e); else pass_n++;
    valid = 0; cond = C_AL; #1;
    total_n++; if (condex !== 1'b0) $display("FAIL invalid_condex got=%b exp=0", condex); else pass_n++;
    idle();
  endtask

  task automatic test_banks();
    exp_q.push_back(4'b0010); load(4'b0010);
    e = exp_q.pop_front();
    total_n++; if (flags !== e) $display("FAIL bank0_load got=%b exp=%b", flags, e); else pass_n++;
    bsel = 1; valid = 1; cond = C_AL; alu = 4'b1001; wr = 2'b11;
    exp_q.push_back(4'b1001); tick();
    e = exp_q.pop_front();
    total_n++; if (flags !== e) $display("FAIL bank1_write got=%b exp=%b", flags, e); else pass_n++;
    idle(); bsel = 1; valid = 1; alu = 4'b0110; wr = 2'b01;
    exp_q.push_back(4'b1010); tick();
    e = exp_q.pop_front();
    total_n++; if (flags !== e) $display("FAIL bank1_cv_only got=%b exp=%b", flags, e); else pass_n++;
    idle(); valid = 1; cond = C_MI; #1;
    total_n++; if (flags !== 4'b0010) $display("FAIL bank0_kept got=%b exp=0010", flags); else pass_n++;
    total_n++; if (condex !== 1'b0) $display("FAIL bank0_mi got=%b exp=0", condex); else pass_n++;
    bsel = 1; #1;
    total_n++; if (condex !== 1'b1) $display("FAIL bank1_mi got=%b exp=1", condex); else pass_n++;
    idle();
  endtask

  task automatic test_stack();
    do_reset(); stk_m.delete();
    for (int k = 1; k <= 4; k++) begin
      load(4'(k)); push = 1; stk_m.push_back(4'(k)); tick(); idle();
    end
    total_n++; if (full !== 1'b1) $display("FAIL stack_full got=%b exp=1", full); else pass_n++;
    total_n++; if (err !== 1'b0) $display("FAIL stack_no_err got=%b exp=0", err); else pass_n++;
    push = 1; tick(); idle();
    total_n++; if (err !== 1'b1) $display("FAIL push_full_err got=%b exp=1", err); else pass_n++;
    total_n++; if (full !== 1'b1) $display("FAIL push_full_sp got=%b exp=1", full); else pass_n++;
    for (int k = 0; k < 4; k++) begin
      pop = 1; exp_q.push_back(stk_m.pop_back()); tick(); idle();
      e = exp_q.pop_front();
      total_n++; if (flags !== e) $display("FAIL pop_%0d got=%b exp=%b", k, flags, e); else pass_n++;
    end
    total_n++; if (empty !== 1'b1) $display("FAIL stack_empty got=%b exp=1", empty); else pass_n++;
    pop = 1; ld = 1; ld_data = 4'b0111; exp_q.push_back(4'b0111); tick(); idle();
    e = exp_q.pop_front();
    total_n++; if (flags !== e) $display("FAIL pop_empty_load got=%b exp=%b", flags, e); else pass_n++;
    total_n++; if (empty !== 1'b1) $display("FAIL pop_empty_sp got=%b exp=1", empty); else pass_n++;
  endtask

  task automatic test_push_write();
    do_reset(); load(4'b0001);
    push = 1; valid = 1; cond = C_AL; alu = 4'b1111; wr = 2'b11;
    exp_q.push_back(4'b1111); tick(); idle();
    e = exp_q.pop_front();
    total_n++; if (flags !== e) $display("FAIL push_alu_bank got=%b exp=%b", flags, e); else pass_n++;
    load(4'b0110);
    pop = 1; valid = 1; cond = C_AL; alu = 4'b1111; wr = 2'b11;
    exp_q.push_back(4'b0001); tick(); idle();
    e = exp_q.pop_front();
    total_n++; if (flags !== e) $display("FAIL pop_wins got=%b exp=%b", flags, e); else pass_n++;
    total_n++; if (empty !== 1'b1 || err !== 1'b0) $display("FAIL pop_wins_state got=%b%b exp=10", empty, err); else pass_n++;
  endtask

  task automatic test_back_to_back_push_pop();
    do_reset(); load(4'b0101);
    push = 1; tick(); idle();
    push = 1; pop = 1; tick(); idle();
    total_n++; if (err !== 1'b1) $display("FAIL pushpop_err got=%b exp=1", err); else pass_n++;
    total_n++; if (flags !== 4'b0101) $display("FAIL pushpop_flags got=%b exp=0101", flags); else pass_n++;
    total_n++; if (empty !== 1'b0) $display("FAIL pushpop_sp got=%b exp=0", empty); else pass_n++;
    load(4'b1000);
    pop = 1; exp_q.push_back(4'b0101); tick(); idle();
    e = exp_q.pop_front();
    total_n++; if (flags !== e) $display("FAIL pushpop_later_pop got=%b exp=%b", flags, e); else pass_n++;
    total_n++; if (empty !== 1'b1) $display("FAIL pushpop_later_empty got=%b exp=1", empty); else pass_n++;
  endtask

  task automatic test_async_reset();
    do_reset(); load(4'b0011);
    push = 1; pop = 1; tick(); idle();
    push = 1; tick();
    @(negedge clk); rst = 1; #1;
    total_n++; if (empty !== 1'b1) $display("FAIL async_sp got=%b exp=1", empty); else pass_n++;
    total_n++; if (err !== 1'b0) $display("FAIL async_err got=%b exp=0", err); else pass_n++;
    total_n++; if (flags !== 4'b0000) $display("FAIL async_flags got=%b exp=0000", flags); else pass_n++;
    idle(); rst = 0; tick();
    total_n++; if (empty !== 1'b1) $display("FAIL async_after got=%b exp=1", empty); else pass_n++;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout passed=%0d total=%0d", pass_n, total_n);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu_write();
    test_banks();
    test_stack();
    test_push_write();
    test_back_to_back_push_pop();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
